mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, word-address width (1M words).
REQ-002 SHALL have parameter TAG_W, default 8, tag width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have CPU-side ports:
- i_ad  input  64  multiplexed address/data from CPU.
- i_tag  input  TAG_W  write tag.
- i_astb  input  1  address strobe.
- i_atomic  input  1  read-modify-write flag, sampled with i_astb.
- i_rd  input  1  read request.
- i_wr  input  1  write request.
REQ-006 SHALL drive CPU-side outputs:
- o_data  output  64  read data.
- o_tag  output  TAG_W  read tag.
- o_valid  output  1  one-cycle read-data strobe.
- o_err  output  1  sticky protocol-error flag.
REQ-007 SHALL have RAM-side ports for a synchronous RAM with 1-cycle read latency:
- m_addr  output  ADDR_W  word address.
- m_re  output  1  read enable.
- m_we  output  1  write enable.
- m_wdata  output  64  write data.
- m_wtag  output  TAG_W  write tag.
- m_rdata  input  64  read data.
- m_rtag  input  TAG_W  read tag.

Function
REQ-008 SHALL implement FSM states IDLE, ADDR, RD_WAIT and LOCKED.
REQ-009 On i_astb, SHALL latch i_ad[ADDR_W-1:0] into the address register and go to ADDR; if i_atomic=1, SHALL go to LOCKED instead.
REQ-010 When i_rd is sampled at edge k in ADDR or LOCKED, SHALL assert m_re with m_addr=latched address for exactly the cycle after edge k.
REQ-011 For a read, SHALL register m_rdata/m_rtag into o_data/o_tag at edge k+2 and raise o_valid for exactly one cycle (read latency 2 cycles).
REQ-012 When i_wr is sampled at edge k in ADDR or LOCKED, SHALL drive m_we=1, m_wdata=i_ad and m_wtag=i_tag (registered) for exactly the cycle after edge k.
REQ-013 The address SHALL remain latched after a read or write; repeated i_rd/i_wr without a new i_astb reuse it.
REQ-014 In LOCKED, a write SHALL complete the RMW and return the FSM to ADDR.
REQ-015 In LOCKED, i_astb before any write SHALL set o_err, clear the lock and latch the new address.
REQ-016 i_rd and i_wr both high in one cycle SHALL set o_err and perform neither access.
REQ-017 i_rd or i_wr while in IDLE (no address yet) SHALL set o_err and perform no access.
REQ-018 i_astb together with i_rd or i_wr in the same cycle SHALL latch the address and ignore the rd/wr; o_err is not set.
REQ-019 i_rd sampled while in RD_WAIT SHALL be accepted back-to-back (pipelined); each accepted read yields its own o_valid pulse in order.
REQ-020 m_re and m_we SHALL never both be high in the same cycle.
REQ-021 o_data/o_tag SHALL hold their last value while o_valid=0.

Reset
REQ-022 While reset=0 at a rising edge, SHALL set: FSM=IDLE, address=0, m_re=0, m_we=0, o_valid=0, o_err=0, o_data=0, o_tag=0, m_wdata=0, m_wtag=0.
REQ-023 A reset during an in-flight read SHALL suppress its o_valid pulse.
REQ-024 A reset during a LOCKED sequence SHALL release the lock.

Structure
REQ-025 A shared package mem_bus_pkg SHALL hold the FSM state enum, ADDR_W/TAG_W defaults and the memory-clear tag constant 'h34.
REQ-026 SHALL be a single flat module with no sub-modules; the read pipeline is a 2-deep valid shift register inside it.

Verification
REQ-027 Write 'h808c6 then 'h0123456789abcdef/tag 'h34, then read -> m_we pulses once, o_valid two cycles after i_rd, o_data='h0123456789abcdef, o_tag='h34.
REQ-028 astb 'h00010, then three consecutive i_rd cycles -> three o_valid pulses on consecutive cycles with data in order, m_addr='h00010 throughout.
REQ-029 Atomic astb 'h00020, rd, wr 'h5 -> read returns old data; m_we writes 'h5; FSM returns to ADDR; o_err=0.
REQ-030 Atomic astb 'h00020, rd, then astb 'h00030 -> o_err=1 and stays 1; the lock is released.
REQ-031 i_rd and i_wr both high, or i_rd right after reset -> o_err=1; m_re=m_we=0.
REQ-032 reset=0 one cycle after an accepted i_rd -> no o_valid; all outputs 0 on the next cycle.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the CPU-to-RAM bus controller
package mem_bus_pkg;

    localparam int         ADDR_W_DEF  = 20;
    localparam int         TAG_W_DEF   = 8;
    localparam logic [7:0] MEM_CLR_TAG = 8'h34;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        RD_WAIT,
        LOCKED
    } state_t;

endpackage

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: multiplexed CPU address/data bus to 1-cycle-latency synchronous RAM
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       i_ad,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_astb,
    input  logic              i_atomic,
    input  logic              i_rd,
    input  logic              i_wr,
    output logic [63:0]       o_data,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_valid,
    output logic              o_err,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_re,
    output logic              m_we,
    output logic [63:0]       m_wdata,
    output logic [TAG_W-1:0]  m_wtag,
    input  logic [63:0]       m_rdata,
    input  logic [TAG_W-1:0]  m_rtag
);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_pipe;
    logic                w_has_addr;
    logic                w_acc_rd;
    logic                w_acc_wr;
    logic                w_set_err;

    // state register; reset also drops any held lock
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next state: a new address always wins, a lock survives reads and ends on write
    always_comb begin
        w_next = i_astb                   ? ((i_atomic && r_state != LOCKED) ? LOCKED : ADDR) :
                 w_acc_rd                 ? ((r_state == LOCKED) ? LOCKED : RD_WAIT) :
                 w_acc_wr                 ? ADDR :
                 (r_state == RD_WAIT)     ? ADDR : r_state;
    end

    // access decode: rd/wr with a strobe are ignored, conflicting or address-less ones are errors
    always_comb begin
        w_has_addr = r_state != IDLE;
        w_acc_rd   = !i_astb && i_rd && !i_wr && w_has_addr;
        w_acc_wr   = !i_astb && i_wr && !i_rd && w_has_addr;
        w_set_err  = i_astb ? (r_state == LOCKED) : ((i_rd || i_wr) && ((i_rd && i_wr) || !w_has_addr));
    end

    assign m_addr = r_addr;
    assign m_re   = r_pipe[0];

    // datapath: address latch, read-valid shift register, write staging, result capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr  <= '0;
            r_pipe  <= '0;
            m_we    <= 1'b0;
            m_wdata <= '0;
            m_wtag  <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_tag   <= '0;
            o_err   <= 1'b0;
        end else begin
            if (i_astb) r_addr <= i_ad[ADDR_W-1:0];
            r_pipe  <= {r_pipe[0], w_acc_rd};
            m_we    <= w_acc_wr;
            if (w_acc_wr) begin
                m_wdata <= i_ad;
                m_wtag  <= i_tag;
            end
            o_valid <= r_pipe[1];
            if (r_pipe[1]) begin
                o_data <= m_rdata;
                o_tag  <= m_rtag;
            end
            o_err   <= o_err | w_set_err;
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed table, corner sequences and random traffic against a transaction-level model
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] i_ad;
    logic [7:0]  i_tag;
    logic        i_astb, i_atomic, i_rd, i_wr;
    logic [63:0] o_data;
    logic [7:0]  o_tag;
    logic        o_valid, o_err;
    logic [19:0] m_addr;
    logic        m_re, m_we;
    logic [63:0] m_wdata;
    logic [7:0]  m_wtag;
    logic [63:0] m_rdata = '0;
    logic [7:0]  m_rtag = '0;

    int checks = 0;
    int failures = 0;

    mem_bus_ctrl dut (
        .clk(clk), .reset(reset), .i_ad(i_ad), .i_tag(i_tag), .i_astb(i_astb),
        .i_atomic(i_atomic), .i_rd(i_rd), .i_wr(i_wr), .o_data(o_data), .o_tag(o_tag),
        .o_valid(o_valid), .o_err(o_err), .m_addr(m_addr), .m_re(m_re), .m_we(m_we),
        .m_wdata(m_wdata), .m_wtag(m_wtag), .m_rdata(m_rdata), .m_rtag(m_rtag)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] dflt(input logic [19:0] a);
        return {12'hABC, a, 12'h5A5, a, a[7:0] ^ 8'h34};
    endfunction

    logic [71:0] ram [logic [19:0]];

    always @(posedge clk) begin
        if (m_we) ram[m_addr] = {m_wdata, m_wtag};
        if (m_re) {m_rdata, m_rtag} <= ram.exists(m_addr) ? ram[m_addr] : dflt(m_addr);
    end

    typedef struct {
        int          due;
        logic [71:0] w;
    } rd_t;

    logic [71:0] mm [logic [19:0]];
    rd_t         q[$];
    int          edge_n = 0;
    logic [19:0] e_addr = '0;
    logic        e_have = 0, e_lock = 0, e_err = 0, e_re = 0, e_we = 0, e_valid = 0;
    logic [63:0] e_wdata = '0, e_data = '0;
    logic [7:0]  e_wtag = '0, e_tag = '0;

    task automatic model_edge();
        edge_n++;
        if (!reset) begin
            e_addr = '0; e_have = 0; e_lock = 0; e_err = 0; e_re = 0; e_we = 0; e_valid = 0;
            e_wdata = '0; e_data = '0; e_wtag = '0; e_tag = '0;
            q.delete();
            return;
        end
        e_valid = 0;
        if (q.size() > 0 && q[0].due == edge_n) begin
            e_valid = 1;
            {e_data, e_tag} = q[0].w;
            void'(q.pop_front());
        end
        e_re = 0;
        e_we = 0;
        if (i_astb) begin
            if (e_lock) begin
                e_err = 1;
                e_lock = 0;
            end else e_lock = i_atomic;
            e_addr = i_ad[19:0];
            e_have = 1;
        end else if (i_rd || i_wr) begin
            if ((i_rd && i_wr) || !e_have) e_err = 1;
            else if (i_rd) begin
                e_re = 1;
                q.push_back('{edge_n + 2, mm.exists(e_addr) ? mm[e_addr] : dflt(e_addr)});
            end else begin
                e_we = 1;
                e_wdata = i_ad;
                e_wtag = i_tag;
                mm[e_addr] = {i_ad, i_tag};
                e_lock = 0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("m_re", 64'(m_re), 64'(e_re));
        chk("m_we", 64'(m_we), 64'(e_we));
        chk("re_we_excl", 64'(m_re & m_we), 64'h0);
        chk("m_addr", 64'(m_addr), 64'(e_addr));
        chk("o_valid", 64'(o_valid), 64'(e_valid));
        chk("o_data", o_data, e_data);
        chk("o_tag", 64'(o_tag), 64'(e_tag));
        chk("o_err", 64'(o_err), 64'(e_err));
        if (e_we) begin
            chk("m_wdata", m_wdata, e_wdata);
            chk("m_wtag", 64'(m_wtag), 64'(e_wtag));
        end
    endtask

    task automatic step(input logic rs, input logic astb, input logic atomic, input logic rd,
                        input logic wr, input logic [63:0] ad, input logic [7:0] tg);
        reset = rs; i_astb = astb; i_atomic = atomic; i_rd = rd; i_wr = wr; i_ad = ad; i_tag = tg;
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
    endtask

    typedef struct {
        logic        rs, astb, atomic, rd, wr;
        logic [63:0] ad;
        logic [7:0]  tg;
        logic [3:0]  x;
        logic [63:0] xd;
        logic [7:0]  xt;
    } vec_t;

    function automatic vec_t v(input logic rs, input logic astb, input logic atomic, input logic rd,
                               input logic wr, input logic [63:0] ad, input logic [7:0] tg,
                               input logic [3:0] x, input logic [63:0] xd, input logic [7:0] xt);
        vec_t r;
        r.rs = rs; r.astb = astb; r.atomic = atomic; r.rd = rd; r.wr = wr;
        r.ad = ad; r.tg = tg; r.x = x; r.xd = xd; r.xt = xt;
        return r;
    endfunction

    vec_t tv[$];

    initial begin
        logic [5:0]  vb;
        logic [63:0] rad;
        reset = 0; i_astb = 0; i_atomic = 0; i_rd = 0; i_wr = 0; i_ad = '0; i_tag = '0;
        // x = {m_re, m_we, o_valid, o_err}
        tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0, 4'b0000, 64'h0, 8'h0));
        tv.push_back(v(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0, 4'b0001, 64'h0, 8'h0));
        tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0, 4'b0000, 64'h0, 8'h0));
        tv.push_back(v(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h808c6, 8'h0, 4'b0000, 64'h0, 8'h0));
        tv.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0123456789abcdef, 8'h34, 4'b0100, 64'h0, 8'h0));
        tv.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0, 4'b0000, 64'h0, 8'h0));
        tv.push_back(v(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0, 4'b1000, 64'h0, 8'h0));
        tv.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0, 4'b0000, 64'h0, 8'h0));
        tv.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0, 4'b0010, 64'h0123456789abcdef, 8'h34));
        tv.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0, 4'b0000, 64'h0123456789abcdef, 8'h34));
        tv.push_back(v(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h808c6, 8'h0, 4'b0000, 64'h0123456789abcdef, 8'h34));
        tv.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0, 4'b0000, 64'h0123456789abcdef, 8'h34));
        tv.push_back(v(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0, 8'h0, 4'b0001, 64'h0123456789abcdef, 8'h34));
        tv.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0, 4'b0001, 64'h0123456789abcdef, 8'h34));
        @(negedge clk);
        foreach (tv[i]) begin
            step(tv[i].rs, tv[i].astb, tv[i].atomic, tv[i].rd, tv[i].wr, tv[i].ad, tv[i].tg);
            chk($sformatf("vec%0d_flags", i), 64'({m_re, m_we, o_valid, o_err}), 64'(tv[i].x));
            chk($sformatf("vec%0d_data", i), o_data, tv[i].xd);
            chk($sformatf("vec%0d_tag", i), 64'(o_tag), 64'(tv[i].xt));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
        chk("reset_wdata", m_wdata, 64'h0);
        chk("reset_wtag", 64'(m_wtag), 64'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h10, 8'h0);
        vb = '0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b0, i < 3, 1'b0, 64'h0, 8'h0);
            vb = {vb[4:0], o_valid};
        end
        chk("rd3_pulses", 64'(vb), 64'(6'b001110));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h20, 8'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h5, 8'h0);
        idle(2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h40, 8'h0);
        chk("rmw_no_err", 64'(o_err), 64'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h20, 8'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
        idle(2);
        chk("rmw_new_data", o_data, 64'h5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h20, 8'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h30, 8'h0);
        chk("lock_astb_err", 64'(o_err), 64'h1);
        idle(3);
        chk("lock_err_sticky", 64'(o_err), 64'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h50, 8'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
        chk("rst_all_zero", 64'({o_valid, o_err, m_re, m_we}) | o_data | 64'(m_addr), 64'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
        chk("rst_no_valid", 64'(o_valid), 64'h0);
        for (int i = 0; i < 3000; i++) begin
            logic rs, astb, rd, wr;
            rs = $urandom_range(0, 39) != 0;
            astb = $urandom_range(0, 5) == 0;
            rd = $urandom_range(0, 2) == 0;
            wr = $urandom_range(0, 4) == 0 && ($urandom_range(0, 3) == 0 || !rd);
            rad = {$urandom, $urandom};
            if (astb) rad[19:0] = 20'($urandom_range(0, 7));
            step(rs, astb, $urandom_range(0, 2) == 0, rd, wr, rad, 8'($urandom));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
